// File: rtl/lmarv_irq_pkg.sv
// ---------------------------------------------------------------------------
// lmarv_irq_pkg
// Shared definitions for the interrupt request priority encoder:
//   IRQ_N       - number of request lines (8)
//   IRQ_CODE_W  - width of the presented request index (3)
//   irq_state_e - handshake FSM states (IRQ_IDLE, IRQ_PRESENT)
// ---------------------------------------------------------------------------
package lmarv_irq_pkg;

    localparam int IRQ_N      = 8;
    localparam int IRQ_CODE_W = 3;

    typedef enum logic [0:0] {
        IRQ_IDLE    = 1'b0,
        IRQ_PRESENT = 1'b1
    } irq_state_e;

endpackage : lmarv_irq_pkg

// File: rtl/prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
// Purely combinational 8-to-3 priority encoder, active-high inputs,
// index 7 has the highest priority.
// Ports:
//   in  [7:0] - request vector
//   idx [2:0] - index of the highest set bit (0 when no bit is set)
//   any       - at least one bit of 'in' is set
// ---------------------------------------------------------------------------
module prio_enc8
    import lmarv_irq_pkg::*;
(
    input  logic [IRQ_N-1:0]      in,
    output logic [IRQ_CODE_W-1:0] idx,
    output logic                  any
);

    // Highest set index wins; all-zero input falls through to index 0.
    always_comb begin
        idx = 3'd0;
        casez (in)
            8'b1???????: idx = 3'd7;
            8'b01??????: idx = 3'd6;
            8'b001?????: idx = 3'd5;
            8'b0001????: idx = 3'd4;
            8'b00001???: idx = 3'd3;
            8'b000001??: idx = 3'd2;
            8'b0000001?: idx = 3'd1;
            8'b00000001: idx = 3'd0;
            default:     idx = 3'd0;
        endcase
    end

    assign any = |in;

endmodule : prio_enc8

// File: rtl/irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// irq_priority_encoder
// Latched 8-input priority encoder with a valid/ack handshake. Falling edges
// on the active-low request lines are captured into pending bits; the
// highest pending index (7 = highest) is presented to the sequencer and held
// until it is acknowledged.
// Ports:
//   clk          - clock, rising edge
//   nreset       - asynchronous active-low reset
//   nreq   [7:0] - active-low request lines (already synchronous to clk)
//   nEI          - active-low enable; high blocks presenting a new code
//   ack          - sequencer accepts the presented code (only while valid)
//   valid        - code holds a pending request
//   code   [2:0] - index of the presented request, frozen while valid
//   nGS          - active-low group signal, low while any pending bit is set
//   pending[7:0] - pending request bits (readback)
// ---------------------------------------------------------------------------
module irq_priority_encoder
    import lmarv_irq_pkg::*;
(
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [IRQ_N-1:0]      nreq,
    input  logic                  nEI,
    input  logic                  ack,
    output logic                  valid,
    output logic [IRQ_CODE_W-1:0] code,
    output logic                  nGS,
    output logic [IRQ_N-1:0]      pending
);

    logic [IRQ_N-1:0]      req_r;
    logic [IRQ_N-1:0]      prev_r;
    logic [IRQ_N-1:0]      pending_r;
    logic                  ngs_r;
    logic [IRQ_N-1:0]      rise_s;
    logic [IRQ_N-1:0]      clr_s;
    logic [IRQ_N-1:0]      pending_nxt_s;
    irq_state_e            state_r;
    logic                  valid_r;
    logic [IRQ_CODE_W-1:0] code_r;
    logic [IRQ_CODE_W-1:0] prio_idx_s;
    logic                  prio_any_s;

    prio_enc8 u_prio_enc8 (
        .in  (pending_r),
        .idx (prio_idx_s),
        .any (prio_any_s)
    );

    // Edge detect and pending update; a new rise wins over a same-edge clear.
    always_comb begin
        rise_s = req_r & ~prev_r;
        clr_s  = 8'h00;
        if ((state_r == IRQ_PRESENT) && (ack == 1'b1)) begin
            clr_s = 8'h01 << code_r;
        end else begin
            clr_s = 8'h00;
        end
        pending_nxt_s = (pending_r & ~clr_s) | rise_s;
    end

    // Request capture registers; nGS is registered from the next pending
    // value so it changes on the same edge as the pending bits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            req_r     <= 8'h00;
            prev_r    <= 8'h00;
            pending_r <= 8'h00;
            ngs_r     <= 1'b1;
        end else begin
            req_r     <= ~nreq;
            prev_r    <= req_r;
            pending_r <= pending_nxt_s;
            ngs_r     <= ~(|pending_nxt_s);
        end
    end

    // Handshake FSM: present the highest pending index, hold it until ack.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= IRQ_IDLE;
            valid_r <= 1'b0;
            code_r  <= 3'd0;
        end else begin
            case (state_r)
                IRQ_IDLE: begin
                    if (prio_any_s && (nEI == 1'b0)) begin
                        state_r <= IRQ_PRESENT;
                        valid_r <= 1'b1;
                        code_r  <= prio_idx_s;
                    end else begin
                        state_r <= IRQ_IDLE;
                        valid_r <= 1'b0;
                    end
                end
                IRQ_PRESENT: begin
                    // nEI does not abort a presentation; only ack ends it.
                    if (ack == 1'b1) begin
                        state_r <= IRQ_IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= IRQ_PRESENT;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IRQ_IDLE;
                    valid_r <= 1'b0;
                    code_r  <= 3'd0;
                end
            endcase
        end
    end

    assign valid   = valid_r;
    assign code    = code_r;
    assign nGS     = ngs_r;
    assign pending = pending_r;

endmodule : irq_priority_encoder

// File: tb/tb_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_encoder
// Directed bench for irq_priority_encoder. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_irq_priority_encoder;

    logic       clk;
    logic       nreset;
    logic [7:0] nreq;
    logic       nEI;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic       nGS;
    logic [7:0] pending;

    int total;
    int bad;

    irq_priority_encoder dut (
        .clk     (clk),
        .nreset  (nreset),
        .nreq    (nreq),
        .nEI     (nEI),
        .ack     (ack),
        .valid   (valid),
        .code    (code),
        .nGS     (nGS),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] order [4];
        total = 0;
        bad   = 0;
        nreset = 1'b0;
        nreq   = 8'hFF;
        nEI    = 1'b0;
        ack    = 1'b0;
        order[0] = 3'd7; order[1] = 3'd5; order[2] = 3'd2; order[3] = 3'd0;

        // Reset state
        step();
        chk("rst_valid",   {7'd0, valid}, 8'h00);
        chk("rst_code",    {5'd0, code},  8'h00);
        chk("rst_ngs",     {7'd0, nGS},   8'h01);
        chk("rst_pending", pending,       8'h00);
        step();
        nreset = 1'b1;
        step();

        // Single request on line 3
        nreq = 8'hF7;
        step();                                     // E0
        chk("t1_e0_pending", pending, 8'h00);
        step();                                     // E1
        chk("t1_e1_pending", pending, 8'h08);
        chk("t1_e1_ngs",   {7'd0, nGS},   8'h00);
        chk("t1_e1_valid", {7'd0, valid}, 8'h00);
        step();                                     // E2
        chk("t1_e2_valid", {7'd0, valid}, 8'h01);
        chk("t1_e2_code",  {5'd0, code},  8'h03);
        ack = 1'b1;
        step();                                     // ack edge
        ack = 1'b0;
        chk("t1_ack_valid",   {7'd0, valid}, 8'h00);
        chk("t1_ack_pending", pending,       8'h00);
        chk("t1_ack_ngs",     {7'd0, nGS},   8'h01);
        // line 3 still held low: no new request
        step(); step(); step();
        chk("t1_held_valid",   {7'd0, valid}, 8'h00);
        chk("t1_held_pending", pending,       8'h00);
        nreq = 8'hFF;
        step(); step();

        // Priority and no preemption
        nreq = 8'hFB;
        step(); step(); step();
        chk("t2_valid", {7'd0, valid}, 8'h01);
        chk("t2_code2", {5'd0, code},  8'h02);
        nreq = 8'hBB;
        step(); step();
        chk("t2_pend_both", pending, 8'h44);
        chk("t2_nopreempt_code", {5'd0, code},  8'h02);
        chk("t2_nopreempt_vld",  {7'd0, valid}, 8'h01);
        step();
        chk("t2_still_code2", {5'd0, code}, 8'h02);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_gap_valid", {7'd0, valid}, 8'h00);
        chk("t2_gap_pend",  pending,       8'h40);
        step();
        chk("t2_next_valid", {7'd0, valid}, 8'h01);
        chk("t2_next_code",  {5'd0, code},  8'h06);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_end_pend", pending, 8'h00);
        nreq = 8'hFF;
        step(); step();

        // Simultaneous requests 7,5,2,0
        nreq = 8'h5A;
        step(); step();
        chk("t3_pend", pending, 8'hA5);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_valid_%0d", i), {7'd0, valid}, 8'h01);
            chk($sformatf("t3_code_%0d", i),  {5'd0, code},  {5'd0, order[i]});
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk($sformatf("t3_gap_%0d", i), {7'd0, valid}, 8'h00);
            step();
        end
        chk("t3_end_pend",  pending,       8'h00);
        chk("t3_end_valid", {7'd0, valid}, 8'h00);
        nreq = 8'hFF;
        step(); step();

        // Set-vs-clear collision on line 4, then held low
        nreq = 8'hEF;
        step(); step(); step();
        chk("t4_code4", {5'd0, code}, 8'h04);
        nreq = 8'hFF;
        step();
        nreq = 8'hEF;
        step();
        chk("t4_hold_valid", {7'd0, valid}, 8'h01);
        ack = 1'b1;
        step();                                     // rise and clear collide
        ack = 1'b0;
        chk("t4_coll_valid", {7'd0, valid}, 8'h00);
        chk("t4_coll_pend",  pending,       8'h10);
        step();
        chk("t4_re_valid", {7'd0, valid}, 8'h01);
        chk("t4_re_code",  {5'd0, code},  8'h04);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step(); step(); step(); step();
        chk("t4_no3rd_valid", {7'd0, valid}, 8'h00);
        chk("t4_no3rd_pend",  pending,       8'h00);
        nreq = 8'hFF;
        step(); step();

        // Enable gating, ack in IDLE ignored
        nEI  = 1'b1;
        nreq = 8'hFD;
        step(); step();
        chk("t5_pend",  pending,       8'h02);
        chk("t5_ngs",   {7'd0, nGS},   8'h00);
        step();
        chk("t5_blocked", {7'd0, valid}, 8'h00);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t5_idle_ack_pend",  pending,       8'h02);
        chk("t5_idle_ack_valid", {7'd0, valid}, 8'h00);
        nEI = 1'b0;
        step();
        chk("t5_en_valid", {7'd0, valid}, 8'h01);
        chk("t5_en_code",  {5'd0, code},  8'h01);
        ack = 1'b1;
        step();
        ack = 1'b0;
        nreq = 8'hFF;
        step(); step();

        // Asynchronous reset while presenting
        nreq = 8'hFE;
        step(); step(); step();
        chk("t6_pre_valid", {7'd0, valid}, 8'h01);
        #2;
        nreset = 1'b0;
        #1;
        chk("t6_async_valid", {7'd0, valid}, 8'h00);
        chk("t6_async_pend",  pending,       8'h00);
        chk("t6_async_ngs",   {7'd0, nGS},   8'h01);
        step();
        nreset = 1'b1;
        step();                                     // line 0 still low, sampled
        step();
        chk("t6_rel_pend",  pending,       8'h01);
        chk("t6_rel_valid", {7'd0, valid}, 8'h00);
        step();
        chk("t6_rel_valid2", {7'd0, valid}, 8'h01);
        chk("t6_rel_code",   {5'd0, code},  8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_irq_priority_encoder

// File: doc/irq_priority_encoder.md
# irq_priority_encoder

Latched 8-input priority encoder with a valid/ack handshake. It is the encode-side counterpart to the 3-to-8 chip-select decoder: eight active-low request lines come in, and the index of the highest-numbered pending request goes out as a 3-bit code, 74x148-style with 7 as the highest priority. The block sits between peripheral request lines and the CPU control sequencer. Requests are edge-captured into pending bits, so a short pulse is never lost, and the sequencer acknowledges each code explicitly.

## Interface
- No parameters. Width is fixed at 8 requests and a 3-bit code.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `nreset`  in  1  Asynchronous, active-low reset.
- `nreq`  in  8  Active-low request lines. A high-to-low transition raises a request.
- `nEI`  in  1  Active-low enable. While high, no new code is presented.
- `ack`  in  1  Sequencer accepts the presented code. Sampled only while `valid` is 1.
- `valid`  out  1  `code` holds a pending request.
- `code`  out  3  Index of the presented request.
- `nGS`  out  1  Active-low group signal. Low when any pending bit is set.
- `pending`  out  8  Pending bits, for debug and readback.

## Operation
- Capture path:
  - `req_q <= ~nreq` every edge.
  - `prev_q <= req_q` every edge.
  - `rise = req_q & ~prev_q`.
  - `pending <= (pending & ~clr) | rise`.
  - `clr` is one-hot at `code` on an accepted ack, otherwise 0.
- Set beats clear: if `rise[i]` and `clr[i]` occur on the same edge, `pending[i]` stays 1.
- Held-low lines raise exactly one request. A line held low after its ack produces no new request until it goes high and then low again.
- FSM with two states:
  - IDLE: `valid=0`. If `pending!=0` and `nEI==0`, then `code <= prio(pending)` and go to PRESENT.
  - PRESENT: `valid=1` and `code` is frozen. If `ack==1`, clear `pending[code]` and go to IDLE.
- `prio()` returns the highest set index. It is only evaluated when its input is nonzero.
- No preemption: a higher request arriving during PRESENT waits until after the ack.
- `ack` while in IDLE is ignored and has no side effects.
- `nEI` high:
  - Blocks IDLE→PRESENT.
  - Does not abort a PRESENT in progress.
  - Pending capture continues.
- `nGS = ~|pending`, registered via `pending` with no extra delay.
- Reset (asynchronous, also mid-operation) clears:
  - `req_q`, `prev_q` and `pending` to 0.
  - State to IDLE, `valid=0`, `code=0`, `nGS=1`.
- After reset, a line that is already low is seen as a new request, because `prev_q=0`.

## Timing
- The edge that samples a `nreq[i]` fall is E0.
  - `pending[i]` and `nGS` change at E1.
  - `valid` and `code` are set at E2, provided the FSM is in IDLE with `nEI=0`.
- Ack at edge Ea, with `valid=1` and `ack=1`:
  - `valid=0` and `pending[code]` clear at Ea.
  - The earliest next `valid` is at Ea+1.
  - So `valid` is low for at least one cycle between codes.
- Back-to-back throughput: one code per 2 cycles.
- `code` is stable for the whole time `valid=1`.
- Outputs are all registered, with no combinational path from input to output.
- `nreq` must already be synchronous to `clk`. Any synchronizer belongs at the board boundary, not in this block.

## Structure
- Shared package `lmarv_irq_pkg`:
  - FSM state constants `IRQ_IDLE` and `IRQ_PRESENT`.
  - `IRQ_N = 8` and `IRQ_CODE_W = 3`.
- One sub-module `prio_enc8`:
  - Purely combinational.
  - Inputs: `in[7:0]`.
  - Outputs: `idx[2:0]` and `any`.
  - Reusable for a future '148 model.
- The top level contains the capture registers, the FSM and the clear logic.

## Test plan
- Single request:
  - Stimulus: reset, then `nreq=8'hFF`; drop `nreq[3]` before E0; `ack` at the first cycle with `valid`.
  - Required: `pending=8'h08` at E1; `valid=1` and `code=3` at E2; `pending=0`, `nGS=1` and `valid=0` after the ack edge.
- Priority and no-preempt:
  - Stimulus: `nreq[2]` falls; once `valid` is up with `code=2`, drop `nreq[6]`; then ack twice.
  - Required: `code` stays 2 until the ack; the next code is 6.
- Simultaneous requests:
  - Stimulus: `nreq` goes to `8'h5A`, i.e. requests 7, 5, 2 and 0; ack each code as it appears.
  - Required: codes are presented in the order 7, 5, 2, 0, each separated by at least one cycle of `valid=0`.
- Set-vs-clear collision and held-low:
  - Stimulus: present code 4; pulse `nreq[4]` high and then low so that its rise lands on the ack edge.
  - Required: `pending[4]` stays 1, and code 4 is re-presented.
  - Holding `nreq[4]` low afterwards produces no third request.
- Enable gating:
  - Stimulus: `nEI=1`, `nreq[1]` falls.
  - Required: `pending=8'h02` and `nGS=0`, with `valid` staying 0.
  - Setting `nEI=0` gives `valid=1` and `code=1` on the next edge.
- Asynchronous reset mid-PRESENT:
  - Stimulus: assert `nreset` while `valid=1`.
  - Required: `valid=0`, `pending=0` and `nGS=1` immediately, without waiting for `clk`.
  - Releasing reset with `nreq[0]` still low gives `code=0` two edges later.
